// File: rtl/sequence_player_pkg.sv
// Shared widths, state encoding and helpers
// for the memory-game sequencer.
package sequence_player_pkg;

  localparam int LED_W  = 7;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_FETCH        = 3'd1,
    S_SHOW         = 3'd2,
    S_GAP          = 3'd3,
    S_PFETCH       = 3'd4,
    S_WAIT_PRESS   = 3'd5,
    S_WAIT_RELEASE = 3'd6,
    S_END          = 3'd7
  } state_t;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sequence_player_timer.sv
// Loadable down-counter shared by the timed states;
// zero flags the final cycle of a load.
module interval_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - WIDTH'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays ROM patterns on the LEDs, then checks
// the player's presses against the same entries.
module sequence_player
  import sequence_player_pkg::*;
#(
  parameter int SHOW_CYCLES    = 50_000_000,
  parameter int GAP_CYCLES     = 25_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [LED_W-1:0]  buttons,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [LED_W-1:0]  rom_data,
  output logic [LED_W-1:0]  leds,
  output logic              busy,
  output logic              done,
  output logic              win,
  output logic              lose,
  output logic              timeout
);

  localparam int TW =
    $clog2(max3(SHOW_CYCLES, GAP_CYCLES,
                TIMEOUT_CYCLES) + 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last;
  logic              t_load;
  logic [TW-1:0]     t_value;
  logic              t_zero;

  interval_timer #(.WIDTH(TW)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (t_load),
    .value (t_value),
    .zero  (t_zero)
  );

  // Reload one cycle ahead so each timed state
  // sees exactly its configured length.
  always_comb begin
    t_load  = 1'b0;
    t_value = '0;
    unique case (state)
      S_FETCH: begin
        t_load  = 1'b1;
        t_value = TW'(SHOW_CYCLES - 1);
      end
      S_SHOW: begin
        t_load  = t_zero;
        t_value = TW'(GAP_CYCLES - 1);
      end
      S_PFETCH: begin
        t_load  = 1'b1;
        t_value = TW'(TIMEOUT_CYCLES - 1);
      end
      default: ;
    endcase
  end

  always_comb begin
    leds = '0;
    if (state == S_SHOW)
      leds = rom_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      last     <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      win      <= 1'b0;
      lose     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          last     <= last_addr;
          idx      <= '0;
          rom_addr <= '0;
          win      <= 1'b0;
          lose     <= 1'b0;
          timeout  <= 1'b0;
          busy     <= 1'b1;
          state    <= S_FETCH;
        end
        S_FETCH: state <= S_SHOW;
        S_SHOW:  if (t_zero) state <= S_GAP;
        S_GAP: if (t_zero) begin
          if (idx != last) begin
            idx      <= idx + ADDR_W'(1);
            rom_addr <= idx + ADDR_W'(1);
            state    <= S_FETCH;
          end else begin
            idx      <= '0;
            rom_addr <= '0;
            state    <= S_PFETCH;
          end
        end
        S_PFETCH: state <= S_WAIT_PRESS;
        S_WAIT_PRESS: begin
          if (buttons != '0) begin
            if (buttons == rom_data) begin
              state <= S_WAIT_RELEASE;
            end else begin
              lose  <= 1'b1;
              done  <= 1'b1;
              state <= S_END;
            end
          end else if (t_zero) begin
            lose    <= 1'b1;
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= S_END;
          end
        end
        S_WAIT_RELEASE: if (buttons == '0) begin
          if (idx != last) begin
            idx      <= idx + ADDR_W'(1);
            rom_addr <= idx + ADDR_W'(1);
            state    <= S_PFETCH;
          end else begin
            win   <= 1'b1;
            done  <= 1'b1;
            state <= S_END;
          end
        end
        S_END: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sequence_player.md
# sequence_player

Controller that sequences the 16-entry pattern ROM (`sync_rom_16x4`: 4-bit address, 7-bit one-hot LED pattern, one-cycle registered read) for the memory game. On `start` it plays entries 0..`last_addr` on the LEDs with fixed on/off timing. It then reads the player's button presses, checks each against the same ROM entries in order, and reports win or lose. It sits between the ROM and the board I/O and is the ROM's only address master.

## Interface
- `SHOW_CYCLES`, default 50_000_000: cycles each pattern is lit; ≥1.
- `GAP_CYCLES`, default 25_000_000: dark cycles after each pattern; ≥1.
- `TIMEOUT_CYCLES`, default 250_000_000: maximum wait for a press; ≥1.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a round; sampled only in IDLE.
- `last_addr` in 4: index of the final entry in the round; captured when `start` is accepted.
- `buttons` in 7: synchronized, debounced button levels; a press is any non-zero value.
- `rom_addr` out 4: registered address to the ROM.
- `rom_data` in 7: ROM `data_out`.
- `leds` out 7: pattern display.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the round ends.
- `win` out 1: level; round ended with every entry matched.
- `lose` out 1: level; round ended on a mismatch or a timeout.
- `timeout` out 1: level; qualifies `lose`, set when the loss was a timeout.

## Operation
- States: IDLE, FETCH, SHOW, GAP, PFETCH, WAIT_PRESS, WAIT_RELEASE, END.
- IDLE
  - When `start`=1: capture `last_addr`, set `idx`=0, set `rom_addr`=0, clear `win`/`lose`/`timeout`, go to FETCH.
- FETCH: lasts 1 cycle. The ROM latches its data on the exit edge, so `rom_data` is valid throughout SHOW.
- SHOW: `leds`=`rom_data` for `SHOW_CYCLES` cycles, then go to GAP.
- GAP: `leds`=0 for `GAP_CYCLES` cycles.
  - If `idx`≠last: `idx`++, `rom_addr`=`idx`+1, go to FETCH.
  - Otherwise: `idx`=0, `rom_addr`=0, go to PFETCH.
- PFETCH: lasts 1 cycle. Loads the timeout counter with `TIMEOUT_CYCLES`.
- WAIT_PRESS: counter decrements each cycle.
  - When `buttons`≠0: compare `buttons`==`rom_data` exactly (all 7 bits).
    - Equal: go to WAIT_RELEASE.
    - Not equal: set `lose`, go to END.
  - When the counter reaches 0 with no press: set `lose` and `timeout`, go to END.
  - A press in the same cycle the counter expires counts as the press; the press takes priority.
- WAIT_RELEASE: wait for `buttons`==0. There is no timeout here.
  - If `idx`≠last: `idx`++, update `rom_addr`, go to PFETCH.
  - Otherwise: set `win`, go to END.
- END: pulse `done` for 1 cycle, go to IDLE. `win`, `lose` and `timeout` hold until the next accepted `start` or `reset`.
- `leds`=0 in every state except SHOW. `leds` is decoded from the state register and `rom_data`, with no extra register.
- `idx` is 4 bits and is compared against last before any increment, so `last_addr`=15 never wraps.
- `start` is ignored while `busy`. `last_addr` changes after capture have no effect.

## Timing
- Reset drives state=IDLE, `rom_addr`=0, `idx`=0, and all outputs to 0, regardless of the current state (including mid-SHOW or mid-WAIT_PRESS).
- With `start` high at edge 0:
  - FETCH in cycle 1, first SHOW in cycle 2.
  - Each entry occupies 1+`SHOW_CYCLES`+`GAP_CYCLES` cycles.
- After the final GAP: PFETCH for 1 cycle, then WAIT_PRESS.
- Press decision latency: the press is evaluated in the same cycle it is sampled. The state changes on the following edge.
- `done` rises 1 cycle after the deciding event (mismatch, timeout, or release) and lasts 1 cycle.
- `win`/`lose` are valid from the same cycle as `done`.

## Structure
- Shared package `sequence_player_pkg`: state encoding localparams, LED width (7), address width (4).
- One sub-module, `interval_timer`: a loadable down-counter with a `zero` flag, sized with `$clog2` of the largest parameter. It is shared by SHOW, GAP and WAIT_PRESS and reloaded on each state entry.
- The ROM is instantiated outside this block.

## Test plan
Use `SHOW_CYCLES`=3, `GAP_CYCLES`=2, `TIMEOUT_CYCLES`=20, with the ROM model attached.
- Playback: `last_addr`=1, `start` at edge 0.
  - `leds` is 0001000 in cycles 2–4, 0 in cycles 5–6, 0010000 in cycles 8–10, then 0.
  - `rom_addr` is 0, then 1, then 0 at PFETCH.
- Win: press 0001000, release, press 0010000, release.
  - `done` pulses 1 cycle after the second release; `win`=1, `lose`=0.
- Mismatch: with `last_addr`=2, press 0001000 then 0000001.
  - `lose`=1, `timeout`=0, `done` pulses; no third compare happens.
- Timeout: no press for 20 cycles in WAIT_PRESS.
  - `lose`=1, `timeout`=1; a press arriving in the expiry cycle is accepted instead.
- Boundary: `last_addr`=15 plays all 16 entries (last shown entry 0010000), with no wrap to 0.
  - A multi-bit press such as 0011000 counts as a mismatch.
- Reset and `start` handling:
  - `reset` mid-SHOW gives `leds`=0, `busy`=0, `rom_addr`=0 the next cycle.
  - `start` pulses while `busy` are ignored (the round completes unchanged).
